// File: rtl/l1_maint_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : l1_maint_sequencer                                              |
// | Broadcasts flush/clear maintenance to NUM_CACHES L1 caches and returns   |
// | one completion pulse. Optional macro L1_MAINT_TIMEOUT_EN adds a phase    |
// | timeout that aborts to DONE with op_err set.                             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module l1_maint_sequencer #(
  parameter int NUM_CACHES  = 2,
  parameter int SERIAL      = 0,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  output logic                  req_ready,
  output logic                  op_done,
  output logic                  op_err,
  output logic                  busy,
  output logic [NUM_CACHES-1:0] flush,
  output logic [NUM_CACHES-1:0] clear,
  input  logic [NUM_CACHES-1:0] flush_done,
  input  logic [NUM_CACHES-1:0] clear_done
);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_FLUSH = 3'd1;
  localparam logic [2:0] c_ST_GAP   = 3'd2;
  localparam logic [2:0] c_ST_CLEAR = 3'd3;
  localparam logic [2:0] c_ST_DONE  = 3'd4;

  localparam logic [NUM_CACHES-1:0] c_ENTRY =
    (SERIAL != 0) ? NUM_CACHES'(1) : {NUM_CACHES{1'b1}};

  if (NUM_CACHES < 1 || NUM_CACHES > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("l1_maint_sequencer: illegal NUM_CACHES or TIMEOUT_CYC");
  end

  logic [2:0]            r_state;
  logic                  r_do_clear;
  logic [NUM_CACHES-1:0] r_req;
  logic [NUM_CACHES-1:0] r_got;

  logic                  w_in_phase;
  logic [NUM_CACHES-1:0] w_done_in;
  logic [NUM_CACHES-1:0] w_hit;
  logic [NUM_CACHES-1:0] w_got_nxt;
  logic [NUM_CACHES-1:0] w_req_adv;
  logic                  w_phase_end;
  logic                  w_abort;

  assign w_in_phase  = (r_state == c_ST_FLUSH) || (r_state == c_ST_CLEAR);
  assign w_done_in   = (r_state == c_ST_FLUSH) ? flush_done :
                       (r_state == c_ST_CLEAR) ? clear_done : '0;
  // Dones only count while the matching request is high, so stale levels are ignored.
  assign w_hit       = w_done_in & r_req;
  assign w_got_nxt   = r_got | w_hit;
  assign w_phase_end = w_in_phase && (&w_got_nxt);

  if (SERIAL != 0) begin : g_serial
    // Hand the single active request on to the next cache in the same edge it drops.
    assign w_req_adv = (r_req & ~w_hit) | (w_hit << 1);
  end else begin : g_parallel
    assign w_req_adv = r_req & ~w_hit;
  end

`ifdef L1_MAINT_TIMEOUT_EN
  localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

  logic [c_TW-1:0] r_cnt;
  logic            r_err;
  logic            w_step;

  assign w_step  = (SERIAL != 0) && (|w_hit);
  assign w_abort = w_in_phase && !w_phase_end && (r_cnt == c_TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (!w_in_phase || w_step) r_cnt <= '0;
      else                       r_cnt <= r_cnt + c_TW'(1);
      if (r_state == c_ST_IDLE && req_valid) r_err <= 1'b0;
      else if (w_abort)                      r_err <= 1'b1;
    end
  end

  assign op_err = (r_state == c_ST_DONE) && r_err;
`else
  assign w_abort = 1'b0;
  assign op_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state    <= c_ST_IDLE;
      r_do_clear <= 1'b0;
      r_req      <= '0;
      r_got      <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (req_valid) begin
            r_do_clear <= req_op[1];
            if (req_op[0]) begin
              r_state <= c_ST_FLUSH;
              r_req   <= c_ENTRY;
            end else if (req_op[1]) begin
              r_state <= c_ST_CLEAR;
              r_req   <= c_ENTRY;
            end else begin
              r_state <= c_ST_DONE;
            end
          end
        end
        c_ST_FLUSH, c_ST_CLEAR: begin
          if (w_phase_end) begin
            r_req   <= '0;
            r_got   <= '0;
            r_state <= (r_state == c_ST_FLUSH && r_do_clear) ? c_ST_GAP : c_ST_DONE;
          end else if (w_abort) begin
            r_req   <= '0;
            r_got   <= '0;
            r_state <= c_ST_DONE;
          end else begin
            r_req <= w_req_adv;
            r_got <= w_got_nxt;
          end
        end
        c_ST_GAP: begin
          r_state <= c_ST_CLEAR;
          r_req   <= c_ENTRY;
        end
        c_ST_DONE: r_state <= c_ST_IDLE;
        default:   r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign flush     = (r_state == c_ST_FLUSH) ? r_req : '0;
  assign clear     = (r_state == c_ST_CLEAR) ? r_req : '0;
  assign req_ready = (r_state == c_ST_IDLE);
  assign busy      = (r_state != c_ST_IDLE);
  assign op_done   = (r_state == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_l1_maint_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module : tb_l1_maint_sequencer                                           |
// | Scoreboard bench: parallel 2-cache and serial 3-cache sequencers.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_l1_maint_sequencer;

  logic clk = 1'b0;
  logic nRST;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic       p_req_valid, p_req_ready, p_op_done, p_op_err, p_busy;
  logic [1:0] p_req_op, p_flush, p_clear, p_fd, p_cd;
  logic       s_req_valid, s_req_ready, s_op_done, s_op_err, s_busy;
  logic [1:0] s_req_op;
  logic [2:0] s_flush, s_clear, s_fd, s_cd;

  typedef struct {
    int   cyc;
    logic err;
  } done_t;

  done_t      p_done_q[$];
  done_t      s_done_q[$];
  logic [3:0] p_req_q[$];
  logic [5:0] s_req_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l1_maint_sequencer #(.NUM_CACHES(2), .SERIAL(0), .TIMEOUT_CYC(16)) dut_par (
    .clk(clk), .nRST(nRST), .req_valid(p_req_valid), .req_op(p_req_op),
    .req_ready(p_req_ready), .op_done(p_op_done), .op_err(p_op_err), .busy(p_busy),
    .flush(p_flush), .clear(p_clear), .flush_done(p_fd), .clear_done(p_cd)
  );

  l1_maint_sequencer #(.NUM_CACHES(3), .SERIAL(1), .TIMEOUT_CYC(1024)) dut_ser (
    .clk(clk), .nRST(nRST), .req_valid(s_req_valid), .req_op(s_req_op),
    .req_ready(s_req_ready), .op_done(s_op_done), .op_err(s_op_err), .busy(s_busy),
    .flush(s_flush), .clear(s_clear), .flush_done(s_fd), .clear_done(s_cd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  // Pops the scoreboard whenever either DUT presents a completion or a cache request.
  task automatic monitor();
    done_t d;
    forever begin
      @(negedge clk);
      if (nRST) begin
        if (p_op_done) begin
          if (p_done_q.size() == 0) check("p_op_done_spurious", 32'(p_op_done), 32'd0);
          else begin
            d = p_done_q.pop_front();
            check("p_op_done_cycle", 32'(cyc), 32'(d.cyc));
            check("p_op_err", 32'(p_op_err), 32'(d.err));
          end
        end
        if ((p_flush | p_clear) != 2'b00) begin
          check("p_flush_clear_overlap", 32'(p_flush & p_clear), 32'd0);
          if (p_req_q.size() == 0) check("p_req_spurious", 32'({p_flush, p_clear}), 32'd0);
          else check("p_req_vec", 32'({p_flush, p_clear}), 32'(p_req_q.pop_front()));
        end
        if (s_op_done) begin
          if (s_done_q.size() == 0) check("s_op_done_spurious", 32'(s_op_done), 32'd0);
          else begin
            d = s_done_q.pop_front();
            check("s_op_done_cycle", 32'(cyc), 32'(d.cyc));
            check("s_op_err", 32'(s_op_err), 32'(d.err));
          end
        end
        if ((s_flush | s_clear) != 3'b000) begin
          check("s_flush_clear_overlap", 32'(s_flush & s_clear), 32'd0);
          if (s_req_q.size() == 0) check("s_req_spurious", 32'({s_flush, s_clear}), 32'd0);
          else check("s_req_vec", 32'({s_flush, s_clear}), 32'(s_req_q.pop_front()));
        end
      end
    end
  endtask

  initial begin
    int x;
    nRST        = 1'b0;
    p_req_valid = 1'b0; p_req_op = 2'b00; p_fd = 2'b00;  p_cd = 2'b00;
    s_req_valid = 1'b0; s_req_op = 2'b00; s_fd = 3'b111; s_cd = 3'b111;
    fork
      monitor();
    join_none
    tick(); tick(); tick();
    nRST = 1'b1;
    tick();

    check("rst_req_ready", 32'(p_req_ready), 32'd1);
    check("rst_busy",      32'(p_busy),      32'd0);
    check("rst_flush",     32'(p_flush),     32'd0);
    check("rst_clear",     32'(p_clear),     32'd0);
    check("rst_op_done",   32'(p_op_done),   32'd0);
    check("rst_op_err",    32'(p_op_err),    32'd0);
    check("rst_s_ready",   32'(s_req_ready), 32'd1);

    // Parallel flush-only, dones 3 and 7 cycles after the requests rise
    x = cyc;
    p_req_op = 2'b01; p_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) p_req_q.push_back(4'b1100);
    for (int i = 0; i < 4; i++) p_req_q.push_back(4'b1000);
    p_done_q.push_back('{cyc: x + 9, err: 1'b0});
    tick();
    p_req_valid = 1'b0;
    check("p_busy_in_flush",  32'(p_busy),      32'd1);
    check("p_ready_in_flush", 32'(p_req_ready), 32'd0);
    wait_until(x + 4); p_fd = 2'b01;
    tick();            p_fd = 2'b00;
    wait_until(x + 8); p_fd = 2'b10;
    tick();            p_fd = 2'b00;
    wait_until(x + 12);

    // Serial flush then clear, all dones held high
    x = cyc;
    s_req_op = 2'b11; s_req_valid = 1'b1;
    s_req_q.push_back(6'b001000); s_req_q.push_back(6'b010000); s_req_q.push_back(6'b100000);
    s_req_q.push_back(6'b000001); s_req_q.push_back(6'b000010); s_req_q.push_back(6'b000100);
    s_done_q.push_back('{cyc: x + 8, err: 1'b0});
    tick();
    s_req_valid = 1'b0;
    wait_until(x + 12);

    // Back-to-back no-op requests with valid held high
    x = cyc;
    p_req_op = 2'b00; p_req_valid = 1'b1;
    p_done_q.push_back('{cyc: x + 1, err: 1'b0});
    p_done_q.push_back('{cyc: x + 3, err: 1'b0});
    tick(); tick(); tick();
    p_req_valid = 1'b0;
    wait_until(x + 6);

    // Stale done levels held from idle, then clear-only sampled in the entry cycle
    p_fd = 2'b11; p_cd = 2'b11;
    tick(); tick(); tick();
    x = cyc;
    p_req_op = 2'b10; p_req_valid = 1'b1;
    p_req_q.push_back(4'b0011);
    p_done_q.push_back('{cyc: x + 2, err: 1'b0});
    tick();
    p_req_valid = 1'b0;
    tick();
    p_fd = 2'b00; p_cd = 2'b00;
    wait_until(x + 5);

    // Spurious idle pulses, then flush+clear with staggered dones
    p_fd = 2'b11; p_cd = 2'b11;
    tick();
    p_fd = 2'b00; p_cd = 2'b00;
    tick();
    x = cyc;
    p_req_op = 2'b11; p_req_valid = 1'b1;
    p_req_q.push_back(4'b1100); p_req_q.push_back(4'b1100); p_req_q.push_back(4'b0100);
    p_req_q.push_back(4'b0011); p_req_q.push_back(4'b0011);
    p_done_q.push_back('{cyc: x + 7, err: 1'b0});
    tick();
    p_req_valid = 1'b0;
    wait_until(x + 2); p_fd = 2'b10;
    tick();            p_fd = 2'b01;
    tick();            p_fd = 2'b00;
    wait_until(x + 6); p_cd = 2'b11;
    tick();            p_cd = 2'b00;
    wait_until(x + 10);

    // Reset in the middle of a flush: no completion may follow
    x = cyc;
    p_req_op = 2'b11; p_req_valid = 1'b1;
    p_req_q.push_back(4'b1100);
    tick();
    p_req_valid = 1'b0;
    tick();
    nRST = 1'b0;
    #1;
    check("mid_rst_flush",   32'(p_flush),     32'd0);
    check("mid_rst_clear",   32'(p_clear),     32'd0);
    check("mid_rst_busy",    32'(p_busy),      32'd0);
    check("mid_rst_op_done", 32'(p_op_done),   32'd0);
    check("mid_rst_ready",   32'(p_req_ready), 32'd1);
    tick(); tick();
    nRST = 1'b1;
    tick();
    check("post_rst_ready", 32'(p_req_ready), 32'd1);
    check("post_rst_busy",  32'(p_busy),      32'd0);
    wait_until(x + 10);

`ifdef L1_MAINT_TIMEOUT_EN
    // Cache 1 never answers flush: abort after 16 phase cycles, clear skipped
    x = cyc;
    p_req_op = 2'b11; p_req_valid = 1'b1;
    p_req_q.push_back(4'b1100);
    for (int i = 0; i < 15; i++) p_req_q.push_back(4'b1000);
    p_done_q.push_back('{cyc: x + 17, err: 1'b1});
    tick();
    p_req_valid = 1'b0;
    p_fd = 2'b01;
    tick();
    p_fd = 2'b00;
    wait_until(x + 22);
`endif

    tick(); tick();
    check("p_done_q_drained", 32'(p_done_q.size()), 32'd0);
    check("p_req_q_drained",  32'(p_req_q.size()),  32'd0);
    check("s_done_q_drained", 32'(s_done_q.size()), 32'd0);
    check("s_req_q_drained",  32'(s_req_q.size()),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
